// File: rtl/alu_cmd_sequencer.sv
// Command-issue stage in front of the two-operand ALU: buffers {op, a, b} commands,
// issues them one at a time and returns each registered ALU result with its opcode.
module alu_cmd_sequencer #(
  parameter int PART_LEN = 8,
  parameter int DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*PART_LEN-1:0]     in_a,
  input  logic [2*PART_LEN-1:0]     in_b,
  input  logic [1:0]                in_op,
  output logic [2*PART_LEN-1:0]     alu_a,
  output logic [2*PART_LEN-1:0]     alu_b,
  output logic [1:0]                alu_ctrl,
  input  logic [2*PART_LEN-1:0]     alu_res,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*PART_LEN-1:0]     out_res,
  output logic [1:0]                out_op,
  output logic                      out_err,
  output logic [$clog2(DEPTH):0]    fifo_count
);

  localparam int W  = 2 * PART_LEN;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXEC   = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [1:0] OP_RSVD = 2'b11;

  logic [1:0]    memOp [DEPTH];
  logic [W-1:0]  memA  [DEPTH];
  logic [W-1:0]  memB  [DEPTH];

  logic [AW-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  aluA_q, aluA_d, aluB_q, aluB_d;
  logic [1:0]    aluCtrl_q, aluCtrl_d;
  logic          outValid_q, outValid_d, outErr_q, outErr_d;
  logic [W-1:0]  outRes_q, outRes_d;
  logic [1:0]    outOp_q, outOp_d;

  logic          push, pop, notEmpty;
  logic [1:0]    headOp;
  logic [W-1:0]  headA, headB;

  assign notEmpty = (count_q != '0);
  assign in_ready = (count_q != FULL);
  assign push     = in_valid && in_ready;
  assign pop      = notEmpty && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign headOp   = memOp[rdPtr_q];
  assign headA    = memA[rdPtr_q];
  assign headB    = memB[rdPtr_q];

  // Storage is not reset; clearing the pointers and count discards its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      memOp[wrPtr_q] <= in_op;
      memA[wrPtr_q]  <= in_a;
      memB[wrPtr_q]  <= in_b;
    end
  end

  always_comb begin
    wrPtr_d    = push ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d    = pop  ? rdPtr_q + 1'b1 : rdPtr_q;
    count_d    = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;

    state_d    = state_q;
    op_d       = op_q;
    aluA_d     = aluA_q;
    aluB_d     = aluB_q;
    aluCtrl_d  = aluCtrl_q;
    outValid_d = outValid_q;
    outRes_d   = outRes_q;
    outOp_d    = outOp_q;
    outErr_d   = outErr_q;

    case (state_q)
      IDLE: begin
        aluCtrl_d = 2'b00;
        if (pop) state_d = EXEC;
      end
      EXEC: state_d = SETTLE;
      SETTLE: begin
        outValid_d = 1'b1;
        outOp_d    = op_q;
        outErr_d   = (op_q == OP_RSVD);
        outRes_d   = (op_q == OP_RSVD) ? '0 : alu_res;
        state_d    = DONE;
      end
      DONE: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          if (pop) begin
            state_d = EXEC;
          end else begin
            aluCtrl_d = 2'b00;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The reserved op would clear the ALU, so it is issued as a harmless add of zeros.
    if (pop) begin
      op_d = headOp;
      if (headOp == OP_RSVD) begin
        aluA_d    = '0;
        aluB_d    = '0;
        aluCtrl_d = 2'b00;
      end else begin
        aluA_d    = headA;
        aluB_d    = headB;
        aluCtrl_d = headOp;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      state_q    <= IDLE;
      op_q       <= 2'b00;
      aluA_q     <= '0;
      aluB_q     <= '0;
      aluCtrl_q  <= 2'b00;
      outValid_q <= 1'b0;
      outRes_q   <= '0;
      outOp_q    <= 2'b00;
      outErr_q   <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      state_q    <= state_d;
      op_q       <= op_d;
      aluA_q     <= aluA_d;
      aluB_q     <= aluB_d;
      aluCtrl_q  <= aluCtrl_d;
      outValid_q <= outValid_d;
      outRes_q   <= outRes_d;
      outOp_q    <= outOp_d;
      outErr_q   <= outErr_d;
    end
  end

  assign alu_a      = aluA_q;
  assign alu_b      = aluB_q;
  assign alu_ctrl   = aluCtrl_q;
  assign out_valid  = outValid_q;
  assign out_res    = outRes_q;
  assign out_op     = outOp_q;
  assign out_err    = outErr_q;
  assign fifo_count = count_q;

endmodule
